imem_loader: RTL
================

# imem_loader

Instruction-memory loader and fetch-side read port for the tiny processor. Owns the 16 x 8-bit instruction memory, presets it to the default program on reset, and lets a user overwrite it byte-by-byte from the input pins through a slow external strobe. It sits directly upstream of the fetch/decode stage: fetch supplies `pc` and consumes `inst`, and the processor core stalls while `cpu_hold` is high.

## Interface
- `IMEM_SZ`, 16: instruction memory depth. Must be 16, so the address width is 4.
- `INST_W`, 8: instruction width.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: reset, asynchronous and active-low.
- `prog_mode` in 1: asynchronous level. High requests program mode.
- `prog_strobe` in 1: asynchronous write strobe. A rising edge captures one byte.
- `prog_data` in 8: byte to load. Must be stable from before the `prog_strobe` rise until 3 `clk` cycles after it.
- `pc` in 4: fetch address.
- `inst` out 8: `imem[pc]`, combinational read.
- `cpu_hold` out 1: high while the core must not advance `pc` or commit state.
- `wr_addr` out 4: next write address.
- `checksum` out 8: sum modulo 256 of the bytes loaded in the current or last session.
- `full` out 1: all 16 locations written this session.

## Operation
Synchronizers and edge detection:
- `prog_mode` and `prog_strobe` each pass through a 2-flop synchronizer, giving `mode_s` and `strb_s`.
- A third flop on `strb_s` produces a one-cycle `strb_rise` pulse.

FSM states are `RUN`, `LOAD` and `FLUSH`. The reset state is `RUN`.
- **`RUN`**:
  - `cpu_hold` = 0.
  - `strb_rise` is ignored.
  - If `mode_s` = 1, go to `LOAD`, and in the same edge set `wr_addr` <= 0, `checksum` <= 0, `full` <= 0.
- **`LOAD`**:
  - `cpu_hold` = 1.
  - If `mode_s` = 0, go to `FLUSH`. Any `strb_rise` in that same cycle is dropped, because mode exit wins.
  - Otherwise, if `strb_rise` and !`full`:
    - write `imem[wr_addr]` <= `prog_data`;
    - `checksum` <= `checksum` + `prog_data` (8-bit, carry discarded);
    - `wr_addr` <= `wr_addr` + 1 (4-bit wrap).
  - The write at `wr_addr` = 15 also sets `full` <= 1, and `wr_addr` wraps to 0.
  - A `strb_rise` while `full` = 1 is ignored: no write, and no change to `checksum` or `wr_addr`.
- **`FLUSH`**:
  - `cpu_hold` = 1 for exactly one cycle, then go to `RUN`.
  - `wr_addr`, `checksum` and `full` hold their values until the next `LOAD` entry.

Memory contents:
- Locations not written in a session keep their prior contents.
- `inst` always reflects the current array contents, including during `LOAD`.

Reset (`rst_n` low, asynchronous):
- All flops and the memory reset immediately, without a clock edge.
- The memory is preset to the default image: [0]=0x44, [1]=0x0F, [2]=0x1E, [3]=0x22, [4]=0x1F, [5]=0x0E, [6]=0xF2, [7]=0x13, [8..15]=0x00.
- Synchronizer flops reset to 0.
- Reset in the middle of a load aborts the session. Partially loaded bytes are lost, because the default image is restored.

## Timing
Reset values:
- `cpu_hold` = 0, `wr_addr` = 0, `checksum` = 0, `full` = 0, state `RUN`.
- `inst` = `imem[pc]` of the default image, so 0x44 at `pc` = 0.

Latencies, where edge N is the first `clk` edge that samples the input high:
- **Strobe to write**: the `prog_strobe` rise is seen at edge N. `strb_rise` is high during the cycle after edge N+1. The write, `checksum` and `wr_addr` update at edge N+2, and `inst` shows the new byte after edge N+2.
- **Entering program mode**: `prog_mode` high seen at edge N gives state `LOAD` and `cpu_hold` = 1 after edge N+2.
- **Leaving program mode**: `prog_mode` low seen at edge N gives `FLUSH` after N+2, `RUN` after N+3, and `cpu_hold` = 0 after edge N+3.

Strobe rules:
- Minimum strobe high time and low time: 3 `clk` cycles each.
- A strobe held high for any duration produces exactly one write.

`cpu_hold` is registered, with no combinational path from the pins.

## Test plan
1. **Reset image**: pulse `rst_n` low with `clk` stopped, then sweep `pc` 0..15. Required: `inst` = 0x44, 0x0F, 0x1E, 0x22, 0x1F, 0x0E, 0xF2, 0x13, then 0x00 x 8. Also `cpu_hold` = 0, `checksum` = 0, `full` = 0.
2. **Short load**: `prog_mode` high, load 0xA1, 0xB2, 0xC3, then `prog_mode` low. Required: `wr_addr` = 3, `checksum` = 0x16. `inst` at `pc` 0..3 = 0xA1, 0xB2, 0xC3, 0x22. `cpu_hold` falls exactly 3 edges after `prog_mode` low is sampled.
3. **Overflow**: in one session, load 17 bytes 0x01..0x11. Required: memory [i] = i+1, `full` = 1 after the 16th write, `checksum` = 0x88, `wr_addr` = 0. The 17th byte is ignored: `checksum` stays 0x88 and [0] stays 0x01.
4. **Held strobe**: `prog_strobe` high for 20 cycles with `prog_data` = 0x5A. Required: a single write, `wr_addr` 0 -> 1, `checksum` = 0x5A.
5. **Ignored strobe**: strobe pulses while in `RUN`, and a strobe rising in the same cycle that `mode_s` falls. Required: no memory change and no `checksum` or `wr_addr` change.
6. **Reset mid-load**: after 5 bytes of 0xFF, assert `rst_n` low asynchronously between clock edges. Required: immediately `cpu_hold` = 0, `wr_addr` = 0, `checksum` = 0, and `inst` at `pc` = 0 is 0x44 (default image restored).

Source files
------------

// File: rtl/imem_loader.sv
// Instruction memory (16 x 8) with reset-time default program and a byte-serial
// loader driven by slow asynchronous mode/strobe pins; feeds the fetch stage.
module imem_loader #(
    parameter int IMEM_SZ = 16,
    parameter int INST_W  = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       prog_mode,
    input  logic                       prog_strobe,
    input  logic [INST_W-1:0]          prog_data,
    input  logic [$clog2(IMEM_SZ)-1:0] pc,
    output logic [INST_W-1:0]          inst,
    output logic                       cpu_hold,
    output logic [$clog2(IMEM_SZ)-1:0] wr_addr,
    output logic [INST_W-1:0]          checksum,
    output logic                       full
);
    localparam int AW = $clog2(IMEM_SZ);

    typedef enum logic [1:0] {RUN, LOAD, FLUSH} state_t;

    function automatic logic [INST_W-1:0] default_byte(input int idx);
        case (idx)
            0:       return INST_W'(8'h44);
            1:       return INST_W'(8'h0F);
            2:       return INST_W'(8'h1E);
            3:       return INST_W'(8'h22);
            4:       return INST_W'(8'h1F);
            5:       return INST_W'(8'h0E);
            6:       return INST_W'(8'hF2);
            7:       return INST_W'(8'h13);
            default: return '0;
        endcase
    endfunction

    logic              mode_s1_q, mode_s_q;
    logic              strb_s1_q, strb_s_q, strb_dly_q;
    logic              strb_rise;
    state_t            state_q, state_d;
    logic [AW-1:0]     wr_addr_q, wr_addr_d;
    logic [INST_W-1:0] checksum_q, checksum_d;
    logic              full_q, full_d;
    logic              wr_en;
    logic [INST_W-1:0] mem_q [IMEM_SZ];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_s1_q  <= 1'b0;
            mode_s_q   <= 1'b0;
            strb_s1_q  <= 1'b0;
            strb_s_q   <= 1'b0;
            strb_dly_q <= 1'b0;
        end else begin
            mode_s1_q  <= prog_mode;
            mode_s_q   <= mode_s1_q;
            strb_s1_q  <= prog_strobe;
            strb_s_q   <= strb_s1_q;
            strb_dly_q <= strb_s_q;
        end
    end

    // One pulse per strobe rise, however long the strobe stays high.
    assign strb_rise = strb_s_q & ~strb_dly_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            wr_addr_q  <= '0;
            checksum_q <= '0;
            full_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_addr_q  <= wr_addr_d;
            checksum_q <= checksum_d;
            full_q     <= full_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wr_addr_d  = wr_addr_q;
        checksum_d = checksum_q;
        full_d     = full_q;
        wr_en      = 1'b0;
        case (state_q)
            RUN: begin
                if (mode_s_q) begin
                    state_d    = LOAD;
                    wr_addr_d  = '0;
                    checksum_d = '0;
                    full_d     = 1'b0;
                end
            end
            LOAD: begin
                // Leaving program mode takes priority over a coincident strobe.
                if (!mode_s_q) begin
                    state_d = FLUSH;
                end else if (strb_rise && !full_q) begin
                    wr_en      = 1'b1;
                    checksum_d = checksum_q + prog_data;
                    wr_addr_d  = wr_addr_q + AW'(1);
                    if (wr_addr_q == AW'(IMEM_SZ - 1)) begin
                        full_d = 1'b1;
                    end
                end
            end
            FLUSH:   state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < IMEM_SZ; i++) begin
                mem_q[i] <= default_byte(i);
            end
        end else if (wr_en) begin
            mem_q[wr_addr_q] <= prog_data;
        end
    end

    assign inst     = mem_q[pc];
    assign cpu_hold = (state_q != RUN);
    assign wr_addr  = wr_addr_q;
    assign checksum = checksum_q;
    assign full     = full_q;

endmodule
